// File: rtl/morse_pkg.sv
// morse_pkg: shared state type, character codes and default sizing
// for the Morse transmit sequencer.
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ENCODE,
        S_SEND,
        S_GAP,
        S_FIN
    } morse_state_t;

    localparam logic [7:0] CHAR_NUL = 8'h00;

    localparam int DEF_ADR_W    = 17;
    localparam int DEF_CODE_W   = 24;
    localparam int DEF_ROM_LAT  = 1;
    localparam int DEF_CD_LAT   = 1;
    localparam int DEF_CHAR_GAP = 3;
    localparam int DEF_WORD_GAP = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/morse_len_calc.sv
// morse_len_calc: key pattern length = CODE_W minus trailing zeros.
// An all-zero pattern (space) yields 0.
module morse_len_calc
    import morse_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic [CODE_W-1:0] i_code,
    output logic [LEN_W-1:0]  o_len
);

    // Scan MSB to LSB so the lowest set bit wins.
    always_comb begin
        o_len = '0;
        for (int i = CODE_W - 1; i >= 0; i--) begin
            if (i_code[i]) begin
                o_len = LEN_W'(CODE_W - i);
            end
        end
    end

endmodule

// File: rtl/morse_tx_ctrl.sv
// morse_tx_ctrl: walks the character ROM, fetches key patterns from the
// encoder and plays them on key_out one bit per dot tick, with gaps.
module morse_tx_ctrl
    import morse_pkg::*;
#(
    parameter int ADR_W    = DEF_ADR_W,
    parameter int CODE_W   = DEF_CODE_W,
    parameter int ROM_LAT  = DEF_ROM_LAT,
    parameter int CD_LAT   = DEF_CD_LAT,
    parameter int CHAR_GAP = DEF_CHAR_GAP,
    parameter int WORD_GAP = DEF_WORD_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              tick,
    output logic              rom_cs,
    output logic [ADR_W-1:0]  rom_adr,
    input  logic [7:0]        rom_data,
    output logic              cd_en,
    input  logic [CODE_W-1:0] cd_code,
    output logic              key_out,
    output logic              busy,
    output logic              done,
    output logic [ADR_W-1:0]  char_cnt
);

    localparam int LEN_W = $clog2(CODE_W + 1);
    localparam int CNT_W = $clog2(max3(CODE_W, CHAR_GAP, WORD_GAP) + 1);
    localparam int LAT_W = $clog2(max3(ROM_LAT, CD_LAT, 1) + 1);

    morse_state_t      r_state;
    logic [LAT_W-1:0]  r_lat;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_shreg;
    logic              r_key;
    logic [ADR_W-1:0]  r_adr;
    logic [ADR_W-1:0]  r_chars;

    morse_state_t      w_state_nx;
    logic [LAT_W-1:0]  w_lat_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CODE_W-1:0] w_shreg_nx;
    logic              w_key_nx;
    logic [ADR_W-1:0]  w_adr_nx;
    logic [ADR_W-1:0]  w_chars_nx;
    logic              w_rom_cs;
    logic              w_cd_en;
    logic [LEN_W-1:0]  w_len;

    morse_len_calc #(
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W)
    ) u_len (
        .i_code (cd_code),
        .o_len  (w_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_lat   <= '0;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_key   <= 1'b0;
            r_adr   <= '0;
            r_chars <= '0;
        end else begin
            r_state <= w_state_nx;
            r_lat   <= w_lat_nx;
            r_cnt   <= w_cnt_nx;
            r_shreg <= w_shreg_nx;
            r_key   <= w_key_nx;
            r_adr   <= w_adr_nx;
            r_chars <= w_chars_nx;
        end
    end

    // A state change always takes a cycle of its own, so a tick that
    // coincides with one is dropped rather than consumed.
    always_comb begin
        w_state_nx = r_state;
        w_lat_nx   = r_lat;
        w_cnt_nx   = r_cnt;
        w_shreg_nx = r_shreg;
        w_key_nx   = r_key;
        w_adr_nx   = r_adr;
        w_chars_nx = r_chars;
        w_rom_cs   = 1'b0;
        w_cd_en    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_FETCH;
                    w_adr_nx   = '0;
                    w_chars_nx = '0;
                    w_lat_nx   = '0;
                end
            end
            S_FETCH: begin
                if (r_lat == LAT_W'(ROM_LAT)) begin
                    w_lat_nx   = '0;
                    w_state_nx = (rom_data == CHAR_NUL) ? S_FIN : S_ENCODE;
                end else begin
                    w_rom_cs = 1'b1;
                    w_lat_nx = r_lat + 1'b1;
                end
            end
            S_ENCODE: begin
                if (r_lat == LAT_W'(CD_LAT)) begin
                    w_lat_nx   = '0;
                    w_shreg_nx = cd_code;
                    if (w_len == '0) begin
                        w_state_nx = S_GAP;
                        w_cnt_nx   = CNT_W'(WORD_GAP);
                    end else begin
                        w_state_nx = S_SEND;
                        w_cnt_nx   = CNT_W'(w_len);
                    end
                end else begin
                    w_cd_en  = 1'b1;
                    w_lat_nx = r_lat + 1'b1;
                end
            end
            S_SEND: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = CNT_W'(CHAR_GAP);
                end else if (tick) begin
                    w_key_nx   = r_shreg[CODE_W-1];
                    w_shreg_nx = {r_shreg[CODE_W-2:0], 1'b0};
                    w_cnt_nx   = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    if (!(&r_chars)) begin
                        w_chars_nx = r_chars + 1'b1;
                    end
                    // The last ROM word ends the message instead of wrapping.
                    if (&r_adr) begin
                        w_state_nx = S_FIN;
                    end else begin
                        w_adr_nx   = r_adr + 1'b1;
                        w_state_nx = S_FETCH;
                    end
                end else if (tick) begin
                    w_key_nx = 1'b0;
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_FIN: begin
                w_key_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (abort) begin
            w_state_nx = S_IDLE;
            w_key_nx   = 1'b0;
            w_lat_nx   = '0;
            w_cnt_nx   = '0;
        end
    end

    assign rom_cs   = w_rom_cs;
    assign cd_en    = w_cd_en;
    assign rom_adr  = r_adr;
    assign key_out  = r_key;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN);
    assign char_cnt = r_chars;

endmodule
